// File: rtl/mmio_periph.sv
// Memory-mapped peripheral responder: reloadable timer with interrupt, LED/7-segment
// registers and SysTick. Define SYSTICK_EN to build the free-running SysTick counter.
module mmio_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  leds,
    output logic [11:0] bcd7,
    output logic [31:0] systick,
    output logic        irq
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LEDS    = 3'd3;
    localparam logic [2:0] OFF_BCD7    = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  leds_q, leds_d;
    logic [11:0] bcd7_q, bcd7_d;

    logic [2:0]  offset;
    logic        wr_hit;
    logic        overflow;
    logic        irq_set;
    logic        addr_unused;

    assign addr_unused = &{1'b0, addr[1:0]};

    assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset   = addr[4:2];
    assign wr_hit   = wr_en && hit;
    assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    assign irq_set  = overflow && tcon_q[1];

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        leds_d = leds_q;
        bcd7_d = bcd7_q;

        // Reload always takes the pre-edge TH, so a same-edge TH write cannot affect it.
        if (overflow) begin
            tl_d = th_q;
        end else if (tcon_q[0]) begin
            tl_d = tl_q + 32'd1;
        end
        if (irq_set) begin
            tcon_d[2] = 1'b1;
        end

        if (wr_hit) begin
            case (offset)
                OFF_TH:   th_d   = wdata;
                OFF_TL:   tl_d   = wdata;
                // A clearing write never drops an interrupt raised on the same edge.
                OFF_TCON: tcon_d = {wdata[2] | irq_set, wdata[1:0]};
                OFF_LEDS: leds_d = wdata[7:0];
                OFF_BCD7: bcd7_d = wdata[11:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            leds_q <= '0;
            bcd7_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            leds_q <= leds_d;
            bcd7_q <= bcd7_d;
        end
    end

`ifdef SYSTICK_EN
    logic [31:0] systick_q, systick_d;

    always_comb begin
        systick_d = systick_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_d;
        end
    end

    assign systick = systick_q;
`else
    assign systick = '0;
`endif

    always_comb begin
        rdata = '0;
        if (rd_en && hit) begin
            case (offset)
                OFF_TH:      rdata = th_q;
                OFF_TL:      rdata = tl_q;
                OFF_TCON:    rdata = {29'd0, tcon_q};
                OFF_LEDS:    rdata = {24'd0, leds_q};
                OFF_BCD7:    rdata = {20'd0, bcd7_q};
                OFF_SYSTICK: rdata = systick;
                default:     rdata = '0;
            endcase
        end
    end

    assign leds = leds_q;
    assign bcd7 = bcd7_q;
    assign irq  = tcon_q[2];

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_mmio_periph;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LEDS = 32'h4000_000C;
    localparam logic [31:0] A_BCD7 = 32'h4000_0010;
    localparam logic [31:0] A_ST   = 32'h4000_0014;
    localparam logic [31:0] A_RSV  = 32'h4000_0018;
    localparam logic [31:0] A_OUT  = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic [7:0]  leds;
    logic [11:0] bcd7;
    logic [31:0] systick;
    logic        irq;

    mmio_periph dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .hit     (hit),
        .leds    (leds),
        .bcd7    (bcd7),
        .systick (systick),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; the expected SysTick value.
    logic [31:0] cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    function automatic logic [31:0] exp_systick();
`ifdef SYSTICK_EN
        return cyc;
`else
        return 32'd0;
`endif
    endfunction

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1;
        d     = rdata;
        rd_en = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        push("rst_leds", 32'd0);       chk({24'd0, leds});
        push("rst_bcd7", 32'd0);       chk({20'd0, bcd7});
        push("rst_irq", 32'd0);        chk({31'd0, irq});
        push("rst_systick", 32'd0);    chk(systick);
        push("rst_tcon", 32'd0);       rd(A_TCON, r); chk(r);
        push("rst_tl", 32'd0);         rd(A_TL, r);   chk(r);
        tick();
        push("rst_systick_1", exp_systick()); chk(systick);

        // Timer reload
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        push("en_delay_tl", 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        rd(A_TL, r); chk(r);
        push("tl_ff", 32'hFFFF_FFFF);
        push("irq_pre_ovf", 32'd0);
        tick();
        rd(A_TL, r); chk(r);
        chk({31'd0, irq});
        push("tl_reload", 32'hFFFF_FFFC);
        push("irq_set", 32'd1);
        tick();
        rd(A_TL, r); chk(r);
        chk({31'd0, irq});
        for (int k = 1; k <= 10; k++) begin
            push("irq_hold", 32'd1);
            push("tl_run", 32'hFFFF_FFFC + (k % 4));
            tick();
            chk({31'd0, irq});
            rd(A_TL, r); chk(r);
        end

        // Interrupt clear race
        push("tl_wr_ff", 32'hFFFF_FFFF);
        wr(A_TL, 32'hFFFF_FFFF);
        rd(A_TL, r); chk(r);
        push("race_irq", 32'd1);
        push("race_tl", 32'hFFFF_FFFC);
        push("race_tcon", 32'd7);
        wr(A_TCON, 32'd3);
        chk({31'd0, irq});
        rd(A_TL, r); chk(r);
        rd(A_TCON, r); chk(r);
        push("clear_irq", 32'd0);
        push("clear_tcon", 32'd3);
        wr(A_TCON, 32'd3);
        chk({31'd0, irq});
        rd(A_TCON, r); chk(r);

        // TH write during overflow reloads old TH
        wr(A_TL, 32'hFFFF_FFFF);
        push("th_race_tl", 32'hFFFF_FFFC);
        push("th_race_th", 32'h0000_0010);
        push("th_race_irq", 32'd1);
        wr(A_TH, 32'h0000_0010);
        rd(A_TL, r); chk(r);
        rd(A_TH, r); chk(r);
        chk({31'd0, irq});
        push("clear2_irq", 32'd0);
        wr(A_TCON, 32'd3);
        chk({31'd0, irq});

        // TL write priority, then disable holds TL
        push("tl_prio", 32'h0000_1234);
        wr(A_TL, 32'h0000_1234);
        rd(A_TL, r); chk(r);
        push("tl_prio_inc", 32'h0000_1235);
        tick();
        rd(A_TL, r); chk(r);
        push("dis_tl", 32'h0000_1236);
        push("dis_tcon", 32'd0);
        wr(A_TCON, 32'd0);
        rd(A_TL, r); chk(r);
        rd(A_TCON, r); chk(r);
        push("dis_hold", 32'h0000_1236);
        tick();
        rd(A_TL, r); chk(r);

        // Output registers
        wr(A_LEDS, 32'hFFFF_FFA5);
        wr(A_BCD7, 32'hFFFF_F3C6);
        push("leds_port", 32'h0000_00A5);  chk({24'd0, leds});
        push("bcd7_port", 32'h0000_03C6);  chk({20'd0, bcd7});
        push("leds_rd", 32'h0000_00A5);    rd(A_LEDS, r); chk(r);
        push("bcd7_rd", 32'h0000_03C6);    rd(A_BCD7, r); chk(r);

        // Decode
        wr(A_RSV, 32'hFFFF_FFFF);
        push("rsv_rd", 32'd0);             rd(A_RSV, r); chk(r);
        addr = A_OUT;
        rd_en = 1'b1;
        #1;
        push("out_hit", 32'd0);            chk({31'd0, hit});
        push("out_rdata", 32'd0);          chk(rdata);
        rd_en = 1'b0;
        wr(A_OUT, 32'h0000_DEAD);
        push("out_wr_th", 32'h0000_0010);  rd(A_TH, r); chk(r);
        wr(A_ST, 32'h0000_0000);
        push("st_wr_ignored", exp_systick()); chk(systick);
        push("st_rd", exp_systick());      rd(A_ST, r); chk(r);
        addr = A_TH;
        rd_en = 1'b0;
        #1;
        push("rd_en_low_hit", 32'd1);      chk({31'd0, hit});
        push("rd_en_low_rdata", 32'd0);    chk(rdata);

        // Asynchronous reset mid-count
        wr(A_TCON, 32'd1);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        push("arst_leds", 32'd0);          chk({24'd0, leds});
        push("arst_bcd7", 32'd0);          chk({20'd0, bcd7});
        push("arst_systick", 32'd0);       chk(systick);
        push("arst_tl", 32'd0);            rd(A_TL, r); chk(r);
        push("arst_th", 32'd0);            rd(A_TH, r); chk(r);
        push("arst_tcon", 32'd0);          rd(A_TCON, r); chk(r);
        reset = 1'b1;

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
